fifo_rd_gearbox: RTL and testbench
==================================

# fifo_rd_gearbox

Read-side drain engine for the width-converting FIFO, single clock domain (`clk_rd`). Pops RD-width words from the FIFO read port, packs them LSB-first into a bit accumulator and emits OUT-width words on a valid/ready stream. It is the consumer at the read end of the FIFO protocol: it drives `rd_req` and samples `empty`/`rdata`.

## Interface
Parameters:
- `RDDATA_SIZE`, 3, width of FIFO read words.
- `OUT_SIZE`, 4, width of emitted words.
- `ACC_SIZE`, 2*(RDDATA_SIZE+OUT_SIZE), accumulator capacity in bits; must be >= RDDATA_SIZE+OUT_SIZE.

Ports:
- `clk_rd`  in  1  clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `empty`  in  1  FIFO empty flag.
- `rd_req`  out  1  FIFO pop request.
- `rdata`  in  RDDATA_SIZE  FIFO read data, valid the cycle after `rd_req`.
- `out_valid`  out  1  output word available.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  OUT_SIZE  output word.
- `level`  out  clog2(ACC_SIZE+1)  bits currently held in accumulator.
- `flush`  in  1  (only with `GEARBOX_FLUSH_EN`) request emission of partial word.

## Operation
- State: `acc` (ACC_SIZE bits), `level`, `inflight` (1 bit, a pop issued last cycle).
- Pop rule: `rd_req = !empty && (level - (pop_out ? OUT_SIZE : 0) + (inflight ? RDDATA_SIZE : 0) + RDDATA_SIZE <= ACC_SIZE)`. Never pops while `empty`; never overflows the accumulator.
- Capture: when `inflight`, `rdata` is written into `acc` at bit offset `level - (pop_out ? OUT_SIZE : 0)`; `level += RDDATA_SIZE`.
- Output: `out_valid = (level >= OUT_SIZE)`; `out_data = acc[OUT_SIZE-1:0]`. Transfer (`pop_out`) when `out_valid && out_ready`: `acc` shifts right by OUT_SIZE, `level -= OUT_SIZE`.
- Simultaneous capture and transfer in the same cycle: both applied, shift first then append; `level` changes by RDDATA_SIZE-OUT_SIZE.
- Bit order: first FIFO word occupies `out_data` bit 0 upward; words split across output boundaries are continuous.
- Bits above `level` in `acc` are zero.

## Timing
- Reset (`rstn` low at a `clk_rd` edge): `rd_req`=0, `out_valid`=0, `out_data`=0, `level`=0, `inflight`=0, `acc`=0. Reset mid-operation discards held bits and any in-flight word; the FIFO word popped in the cycle before reset is lost.
- `rd_req` in cycle n -> `rdata` sampled at end of cycle n+1 -> `level` updated in cycle n+2.
- First output with defaults: `rd_req` cycles 0,1 (FIFO non-empty) -> `out_valid` first high in cycle 3.
- `out_valid` held with `out_data` stable until `out_ready`; never drops without a transfer except on reset.
- Sustained throughput with `out_ready`=1 and FIFO non-empty: RDDATA_SIZE bits in per cycle, no bubbles after fill.
- `empty` rising: no further `rd_req`; held bits still drain while `level >= OUT_SIZE`.

## Configuration
- `GEARBOX_FLUSH_EN` defined: `flush` port present. When `flush`=1, `!inflight`, `empty`=1 and `0 < level < OUT_SIZE`, `out_valid` asserts with `out_data` = held bits zero-padded at the MSBs; on transfer `level`→0. `rd_req` is held low while a flush word is pending. `flush` with `level`=0 has no effect.
- Not defined: no `flush` port; residual bits below OUT_SIZE stay in the accumulator until enough FIFO data arrives.

## Test plan
- Reset: hold `rstn`=0 2 cycles with `empty`=0 -> `rd_req`=0, `out_valid`=0, `out_data`=0, `level`=0; first `rd_req` in the first cycle after release.
- Packing: FIFO supplies 3'b101, 3'b011, 3'b110, 3'b001, `out_ready`=1 -> outputs 4'hD, 4'h9, 4'h3 in order, then `level`=0.
- Backpressure: same stream, `out_ready`=0 for 20 cycles -> `out_valid`=1 with `out_data`=4'hD stable, `level` saturates at <= 14, `rd_req` stops; on release, 4'hD, 4'h9, 4'h3 with no loss.
- Empty gating: `empty` toggled every other cycle over 40 words -> `rd_req` never high while `empty`=1; output bitstream equals input bitstream.
- Reset mid-stream: assert `rstn`=0 with `level`=5 -> next cycle all outputs at reset values, following stream restarts at bit 0.
- Flush (`GEARBOX_FLUSH_EN`): push 3'b101, then `empty`=1, `flush`=1 -> one word 4'h5, then `level`=0, `out_valid`=0.

Source files
------------

// File: rtl/fifo_rd_gearbox.sv
// Read-side drain engine: pops RDDATA_SIZE-bit FIFO words and repacks them LSB-first into OUT_SIZE-bit stream words.
// Optional GEARBOX_FLUSH_EN macro adds a `flush` port to emit a zero-padded partial word once the FIFO runs dry.
module fifo_rd_gearbox #(
    parameter int RDDATA_SIZE = 3,
    parameter int OUT_SIZE    = 4,
    parameter int ACC_SIZE    = 2 * (RDDATA_SIZE + OUT_SIZE),
    localparam int LW         = $clog2(ACC_SIZE + 1)
) (
    input  logic                   clk_rd,
    input  logic                   rstn,
    input  logic                   empty,
    output logic                   rd_req,
    input  logic [RDDATA_SIZE-1:0] rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_SIZE-1:0]    out_data,
`ifdef GEARBOX_FLUSH_EN
    input  logic                   flush,
`endif
    output logic [LW-1:0]          level
);

    // Two spare bits keep level arithmetic free of wrap-around before the compare.
    localparam int SW = LW + 2;
    localparam logic [SW-1:0] OUT_W = SW'(OUT_SIZE);
    localparam logic [SW-1:0] RD_W  = SW'(RDDATA_SIZE);
    localparam logic [SW-1:0] ACC_W = SW'(ACC_SIZE);

    logic [ACC_SIZE-1:0] acc;
    logic [ACC_SIZE-1:0] acc_nxt;
    logic [ACC_SIZE-1:0] rd_ext;
    logic                inflight;
    logic                pop_out;
    logic                flush_pend;
    logic [SW-1:0]       lvl_w;
    logic [SW-1:0]       base;
    logic [SW-1:0]       proj;
    logic [SW-1:0]       lvl_nxt;

    // NOTE: every signal driven from always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        flush_pend = 1'b0;
`ifdef GEARBOX_FLUSH_EN
        flush_pend = flush && !inflight && empty && (level != '0) && ({2'b00, level} < OUT_W);
`endif
        lvl_w     = {2'b00, level};
        out_valid = (lvl_w >= OUT_W) || flush_pend;
        pop_out   = out_valid && out_ready;
        // Offset where an arriving word lands: after the outgoing word has been shifted away.
        base      = pop_out ? lvl_w - OUT_W : lvl_w;
        proj      = base + (inflight ? RD_W : '0) + RD_W;
        // Gated by rstn so the FIFO is never popped while the engine is held in reset.
        rd_req    = rstn && !empty && !flush_pend && (proj <= ACC_W);

        rd_ext  = {{(ACC_SIZE - RDDATA_SIZE){1'b0}}, rdata};
        acc_nxt = pop_out ? (acc >> OUT_SIZE) : acc;
        if (inflight) begin
            acc_nxt = acc_nxt | (rd_ext << base);
        end

        lvl_nxt = base + (inflight ? RD_W : '0);
        if (pop_out && flush_pend) begin
            lvl_nxt = '0;
        end
    end

    assign out_data = acc[OUT_SIZE-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_rd) begin
        if (!rstn) begin
            acc      <= '0;
            level    <= '0;
            inflight <= 1'b0;
        end else begin
            acc      <= acc_nxt;
            level    <= lvl_nxt[LW-1:0];
            inflight <= rd_req;
        end
    end

endmodule

// File: tb/tb_fifo_rd_gearbox.sv
// Self-checking bench for fifo_rd_gearbox: FIFO model plus bit-level scoreboard of the expected output stream.
module tb_fifo_rd_gearbox;

    localparam int RD  = 3;
    localparam int OW  = 4;
    localparam int ACC = 14;
    localparam int LW  = $clog2(ACC + 1);

    logic          clk_rd    = 1'b0;
    logic          rstn      = 1'b0;
    logic          empty     = 1'b1;
    logic          rd_req;
    logic [RD-1:0] rdata     = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] out_data;
    logic          flush     = 1'b0;
    logic [LW-1:0] level;

    int vectors     = 0;
    int miscompares = 0;

    logic [RD-1:0] fifo[$];
    bit            exp_bits[$];
    logic          hold_empty  = 1'b0;
    logic          pop_pending = 1'b0;
    logic          prev_stall  = 1'b0;
    logic [OW-1:0] prev_data   = '0;

    fifo_rd_gearbox #(
        .RDDATA_SIZE(RD),
        .OUT_SIZE   (OW),
        .ACC_SIZE   (ACC)
    ) dut (
        .clk_rd   (clk_rd),
        .rstn     (rstn),
        .empty    (empty),
        .rd_req   (rd_req),
        .rdata    (rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
`ifdef GEARBOX_FLUSH_EN
        .flush    (flush),
`endif
        .level    (level)
    );

    always #5 clk_rd = ~clk_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic upd_empty();
        empty = hold_empty || (fifo.size() == 0);
    endtask

    task automatic push(input logic [RD-1:0] w);
        fifo.push_back(w);
        for (int i = 0; i < RD; i++) exp_bits.push_back(w[i]);
        upd_empty();
    endtask

    task automatic push_pack_stream();
        push(3'b101);
        push(3'b011);
        push(3'b110);
        push(3'b001);
    endtask

    // Inputs change 2 time units after the rising edge; outputs are stable by then.
    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk_rd);
            #2;
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (exp_bits.size() == 0 && fifo.size() == 0 && level == '0 && !out_valid) begin
                done = 1'b1;
                break;
            end
            cycle(1);
        end
        check({tag, "_drained"}, done, 1'b1);
        check({tag, "_level"}, level, 0);
    endtask

    // FIFO read port: a pop seen on rd_req presents its word the following cycle.
    always @(posedge clk_rd) begin
        #1;
        if (pop_pending && fifo.size() > 0) rdata = fifo.pop_front();
        upd_empty();
    end

    // Output monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk_rd) begin
        logic [OW-1:0] e;
        bit            avail;
        pop_pending = rd_req;
        if (rstn) begin
            check("rd_req_while_empty", rd_req && empty, 1'b0);
            if (prev_stall) begin
                check("valid_hold", out_valid, 1'b1);
                check("data_stable", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                avail = exp_bits.size() > 0;
                e = '0;
                for (int i = 0; i < OW; i++) begin
                    if (exp_bits.size() > 0) e[i] = exp_bits.pop_front();
                end
                check("word_expected", avail, 1'b1);
                check("out_word", out_data, e);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        // Reset with data waiting in the FIFO.
        push_pack_stream();
        cycle(2);
        check("rst_rd_req", rd_req, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 0);
        check("rst_level", level, 0);
        rstn = 1'b1;
        #1;
        check("first_rd_req", rd_req, 1'b1);
        out_ready = 1'b1;
        cycle(2);
        check("fill_valid_c2", out_valid, 1'b0);
        check("fill_level_c2", level, 3);
        cycle(1);
        check("fill_valid_c3", out_valid, 1'b1);
        check("first_word", out_data, 4'hD);
        wait_drain("pack", 40);

        // Backpressure: accumulator saturates, pops stop, nothing lost on release.
        out_ready = 1'b0;
        push_pack_stream();
        push_pack_stream();
        cycle(20);
        check("bp_valid", out_valid, 1'b1);
        check("bp_data", out_data, 4'hD);
        check("bp_level_bound", level <= ACC, 1'b1);
        check("bp_level", level, 12);
        check("bp_rd_req", rd_req, 1'b0);
        check("bp_fifo_nonempty", empty, 1'b0);
        out_ready = 1'b1;
        wait_drain("bp", 60);

        // Empty gating with random downstream readiness.
        for (int i = 0; i < 40; i++) push(RD'($urandom_range(0, 7)));
        for (int i = 0; i < 600; i++) begin
            if (exp_bits.size() == 0 && fifo.size() == 0) break;
            if (i % 2 == 0) hold_empty = ~hold_empty;
            upd_empty();
            out_ready = 1'($urandom_range(0, 1));
            cycle(1);
        end
        hold_empty = 1'b0;
        upd_empty();
        out_ready = 1'b1;
        wait_drain("gate", 60);
        check("gate_bits_left", exp_bits.size(), 0);

        // Reset mid-stream with 5 bits held.
        out_ready = 1'b0;
        push(3'b111);
        push(3'b010);
        push(3'b100);
        cycle(8);
        check("mid_level_9", level, 9);
        out_ready = 1'b1;
        cycle(1);
        out_ready = 1'b0;
        check("mid_level_5", level, 5);
        rstn = 1'b0;
        fifo.delete();
        exp_bits.delete();
        upd_empty();
        cycle(1);
        check("mid_rst_rd_req", rd_req, 1'b0);
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_level", level, 0);
        rstn = 1'b1;
        out_ready = 1'b1;
        push_pack_stream();
        wait_drain("restart", 40);

        // Residual partial word.
        push(3'b101);
        cycle(5);
        check("resid_level", level, 3);
        check("resid_valid", out_valid, 1'b0);
`ifdef GEARBOX_FLUSH_EN
        flush = 1'b1;
        #1;
        check("flush_valid", out_valid, 1'b1);
        check("flush_data", out_data, 4'h5);
        cycle(1);
        check("flush_level", level, 0);
        check("flush_valid_after", out_valid, 1'b0);
        flush = 1'b0;
`else
        cycle(5);
        check("resid_level_hold", level, 3);
        check("resid_valid_hold", out_valid, 1'b0);
        check("resid_data_hold", out_data, 4'h5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
